mmcm_drp_reconfig_ctrl: RTL and testbench

- Sequences dynamic reconfiguration of the clocking MMCM (the clk125 → clk100 generator) through its DRP port.
- On a start request, it selects one of NUM_CFG stored configurations and holds the MMCM in reset.
- It performs a read-modify-write of each configuration register, releases reset, then waits for lock.
- Runs on clk125, the MMCM input clock, so it is never clocked by the output it is reprogramming.

---
 rtl/mmcm_drp_pkg.sv | 58 +++++
 rtl/sync_2ff.sv | 31 +++
 rtl/mmcm_drp_reconfig_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mmcm_drp_reconfig_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_drp_pkg.sv
// rtl/mmcm_drp_pkg.sv - DRP entry type, controller states, error codes and per-frequency MMCM register table
package mmcm_drp_pkg;

  localparam int TBL_CFGS  = 4;
  localparam int TBL_REGS  = 8;
  localparam int TBL_CFG_W = $clog2(TBL_CFGS);
  localparam int TBL_IDX_W = $clog2(TBL_REGS);

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } drp_entry_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ASSERT_RST,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RELEASE,
    ST_WAIT_LOCK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_CFG = 2'd1;
  localparam logic [1:0] ERR_DRDY_TO = 2'd2;
  localparam logic [1:0] ERR_LOCK_TO = 2'd3;

  // Order per row: CLKOUT0 reg1/reg2, CLKFBOUT reg1/reg2, DIVCLK, LOCK, FILT1, FILT2.
  localparam drp_entry_t CFG_TABLE [TBL_CFGS][TBL_REGS] = '{
    '{ '{7'h08, 16'h1000, 16'h1145}, '{7'h09, 16'h8000, 16'h0000},
       '{7'h14, 16'h1000, 16'h1104}, '{7'h15, 16'h8000, 16'h0000},
       '{7'h16, 16'hC000, 16'h1041}, '{7'h18, 16'hFC00, 16'h00FA},
       '{7'h4E, 16'h66FF, 16'h0800}, '{7'h4F, 16'h666F, 16'h1000} },
    '{ '{7'h08, 16'h1000, 16'h1186}, '{7'h09, 16'h8000, 16'h0080},
       '{7'h14, 16'h1000, 16'h1145}, '{7'h15, 16'h8000, 16'h0000},
       '{7'h16, 16'hC000, 16'h1041}, '{7'h18, 16'hFC00, 16'h00E1},
       '{7'h4E, 16'h66FF, 16'h0900}, '{7'h4F, 16'h666F, 16'h1100} },
    '{ '{7'h08, 16'h1000, 16'h1208}, '{7'h09, 16'h8000, 16'h0000},
       '{7'h14, 16'h1000, 16'h1186}, '{7'h15, 16'h8000, 16'h0080},
       '{7'h16, 16'hC000, 16'h1082}, '{7'h18, 16'hFC00, 16'h00C8},
       '{7'h4E, 16'h66FF, 16'h9800}, '{7'h4F, 16'h666F, 16'h0100} },
    '{ '{7'h08, 16'h1000, 16'h1104}, '{7'h09, 16'h8000, 16'h0000},
       '{7'h14, 16'h1000, 16'h1249}, '{7'h15, 16'h8000, 16'h0000},
       '{7'h16, 16'hC000, 16'h1041}, '{7'h18, 16'hFC00, 16'h0113},
       '{7'h4E, 16'h66FF, 16'h1900}, '{7'h4F, 16'h666F, 16'h9000} }
  };

  // Mask bits set to 1 keep the value read back from the MMCM.
  function automatic logic [15:0] drp_merge(input logic [15:0] rdata, input drp_entry_t e);
    return (rdata & e.mask) | (e.data & ~e.mask);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer for asynchronous level signals
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mmcm_drp_reconfig_ctrl.sv
// rtl/mmcm_drp_reconfig_ctrl.sv - MMCM DRP read-modify-write reconfiguration sequencer, clocked by clk125
module mmcm_drp_reconfig_ctrl
  import mmcm_drp_pkg::*;
#(
  parameter int NUM_CFG      = 4,
  parameter int NUM_REGS     = 8,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 125000
) (
  input  logic                       clk125,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(NUM_CFG)-1:0] cfg_sel,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [1:0]                 err_code,
  output logic [$clog2(NUM_CFG)-1:0] cur_cfg,
  output logic [6:0]                 daddr,
  output logic [15:0]                di,
  input  logic [15:0]                dout,
  output logic                       den,
  output logic                       dwe,
  input  logic                       drdy,
  output logic                       mmcm_rst,
  input  logic                       locked
);

  localparam int CFG_W = $clog2(NUM_CFG);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] DRDY_LIMIT = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [15:0]       rdata_q, rdata_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [CFG_W-1:0]  cur_cfg_q, cur_cfg_d;

  logic                 locked_s;
  logic [TBL_CFG_W-1:0] tbl_cfg;
  logic [TBL_IDX_W-1:0] tbl_idx;
  drp_entry_t           entry;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (clk125),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  assign tbl_cfg  = TBL_CFG_W'(cfg_q);
  assign tbl_idx  = TBL_IDX_W'(idx_q);
  assign entry    = CFG_TABLE[tbl_cfg][tbl_idx];
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign err_code = err_code_q;
  assign cur_cfg  = cur_cfg_q;

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_code_d = err_code_q;
    cur_cfg_d  = cur_cfg_q;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    den        = 1'b0;
    dwe        = 1'b0;
    mmcm_rst   = 1'b0;
    daddr      = '0;
    di         = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_d = cfg_sel;
          if (int'(cfg_sel) >= NUM_CFG) begin
            err_code_d = ERR_BAD_CFG;
            state_d    = ST_ERR;
          end else begin
            err_code_d = ERR_NONE;
            idx_d      = '0;
            state_d    = ST_ASSERT_RST;
          end
        end
      end
      ST_ASSERT_RST: begin
        busy     = 1'b1;
        mmcm_rst = 1'b1;
        state_d  = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        busy     = 1'b1;
        mmcm_rst = 1'b1;
        den      = 1'b1;
        daddr    = entry.addr;
        cnt_d    = '0;
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        busy     = 1'b1;
        mmcm_rst = 1'b1;
        if (drdy) begin
          rdata_d = dout;
          state_d = ST_WR_REQ;
        end else if (cnt_q >= DRDY_LIMIT) begin
          err_code_d = ERR_DRDY_TO;
          state_d    = ST_ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WR_REQ: begin
        busy     = 1'b1;
        mmcm_rst = 1'b1;
        den      = 1'b1;
        dwe      = 1'b1;
        daddr    = entry.addr;
        di       = drp_merge(rdata_q, entry);
        cnt_d    = '0;
        state_d  = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        busy     = 1'b1;
        mmcm_rst = 1'b1;
        if (drdy) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_RELEASE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_RD_REQ;
          end
        end else if (cnt_q >= DRDY_LIMIT) begin
          err_code_d = ERR_DRDY_TO;
          state_d    = ST_ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RELEASE: begin
        busy    = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        busy = 1'b1;
        // cur_cfg moves on entry to DONE so it is already valid alongside the done pulse.
        if (locked_s) begin
          cur_cfg_d = cfg_q;
          state_d   = ST_DONE;
        end else if (cnt_q >= LOCK_LIMIT) begin
          err_code_d = ERR_LOCK_TO;
          state_d    = ST_ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        error   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_code_q <= ERR_NONE;
      cur_cfg_q  <= '0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_code_q <= err_code_d;
      cur_cfg_q  <= cur_cfg_d;
    end
  end

endmodule

// File: tb/tb_mmcm_drp_reconfig_ctrl.sv
// tb/tb_mmcm_drp_reconfig_ctrl.sv - scoreboard bench: DRP register model, MMCM lock model, expected-transaction queue
module tb_mmcm_drp_reconfig_ctrl;
  import mmcm_drp_pkg::*;

  localparam int NUM_CFG    = 3;
  localparam int NUM_REGS   = 8;
  localparam int DRDY_TO    = 64;
  localparam int LOCK_TO    = 1000;
  localparam int LOCK_DELAY = 100;

  logic        clk125 = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  cfg_sel = 2'd0;
  logic        busy, done, error, den, dwe, mmcm_rst;
  logic [1:0]  err_code, cur_cfg;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic [15:0] dout = 16'h0;
  logic        drdy = 1'b0;
  logic        locked = 1'b0;

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] data;
  } drp_txn_t;

  drp_txn_t    exp_q[$];
  drp_txn_t    exp_t;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] mem [128];

  int          cyc = 0, rd_count = 0, wr_count = 0, withhold_at = -1;
  int          den_cyc = 0, rel_cyc = 0, err_cyc = 0, lock_cnt = 0;
  bit          lock_en = 1'b1;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [6:0]  pend_addr = '0;
  logic        pend_we = 1'b0;
  logic [15:0] pend_di = '0;
  logic        prev_mmcm_rst = 1'b0;

  mmcm_drp_reconfig_ctrl #(
    .NUM_CFG      (NUM_CFG),
    .NUM_REGS     (NUM_REGS),
    .DRDY_TIMEOUT (DRDY_TO),
    .LOCK_TIMEOUT (LOCK_TO)
  ) dut (
    .clk125   (clk125),
    .rst      (rst),
    .start    (start),
    .cfg_sel  (cfg_sel),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_code (err_code),
    .cur_cfg  (cur_cfg),
    .daddr    (daddr),
    .di       (di),
    .dout     (dout),
    .den      (den),
    .dwe      (dwe),
    .drdy     (drdy),
    .mmcm_rst (mmcm_rst),
    .locked   (locked)
  );

  always #4 clk125 = ~clk125;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // DRP slave answering 3 cycles after den, plus MMCM lock behaviour.
  always @(negedge clk125) begin
    cyc++;
    drdy = 1'b0;
    if (pend) begin
      if (pend_cnt == 1) begin
        pend = 1'b0;
        drdy = 1'b1;
        dout = mem[pend_addr];
        if (pend_we) mem[pend_addr] = pend_di;
      end else begin
        pend_cnt--;
      end
    end
    if (dwe && !den) check("dwe_without_den", den, 1);
    if (den) begin
      check("drp_one_outstanding", pend, 0);
      check("drp_mmcm_rst_high", mmcm_rst, 1);
      if (exp_q.size() == 0) begin
        check("drp_unexpected_txn", exp_q.size(), 1);
      end else begin
        exp_t = exp_q.pop_front();
        check("drp_dwe", dwe, exp_t.we);
        check("drp_daddr", daddr, exp_t.addr);
        if (exp_t.we) check("drp_di", di, exp_t.data);
      end
      if (dwe) wr_count++;
      else rd_count++;
      pend      = 1'b1;
      pend_cnt  = 3;
      pend_addr = daddr;
      pend_we   = dwe;
      pend_di   = di;
      den_cyc   = cyc;
      if (!dwe && rd_count == withhold_at) pend = 1'b0;
    end
    if (mmcm_rst) begin
      lock_cnt = 0;
      locked   = 1'b0;
    end else begin
      if (lock_en && lock_cnt < LOCK_DELAY) lock_cnt++;
      locked = lock_en && (lock_cnt >= LOCK_DELAY);
    end
    if (prev_mmcm_rst && !mmcm_rst) rel_cyc = cyc;
    prev_mmcm_rst = mmcm_rst;
    if (error) err_cyc = cyc;
  end

  task automatic push_cfg(input int c);
    drp_txn_t   t;
    drp_entry_t en;
    for (int i = 0; i < NUM_REGS; i++) begin
      en     = CFG_TABLE[c][i];
      t.we   = 1'b0;
      t.addr = en.addr;
      t.data = 16'h0;
      exp_q.push_back(t);
      t.we   = 1'b1;
      t.data = (mem[en.addr] & en.mask) | (en.data & ~en.mask);
      exp_q.push_back(t);
    end
  endtask

  task automatic pulse_start(input logic [1:0] c);
    cfg_sel = c;
    start   = 1'b1;
    @(negedge clk125);
    start   = 1'b0;
    cfg_sel = 2'd0;
  endtask

  task automatic wait_end(input int limit, output bit got_done, output bit got_err);
    got_done = 1'b0;
    got_err  = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done || error) begin
        got_done = done;
        got_err  = error;
        break;
      end
      @(negedge clk125);
    end
    check("seq_end_seen", got_done | got_err, 1);
  endtask

  initial begin
    bit d, e;
    int rd0, wr0;
    for (int i = 0; i < 128; i++) mem[i] = 16'hFFFF;
    repeat (3) @(negedge clk125);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_den", den, 0);
    check("rst_dwe", dwe, 0);
    check("rst_mmcm_rst", mmcm_rst, 0);
    check("rst_daddr", daddr, 0);
    check("rst_di", di, 0);
    check("rst_err_code", err_code, 0);
    check("rst_cur_cfg", cur_cfg, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk125);

    // Full sequence, cfg 1, registers preloaded 0xFFFF.
    rd0 = rd_count; wr0 = wr_count;
    push_cfg(1);
    pulse_start(2'd1);
    check("s1_busy", busy, 1);
    wait_end(2000, d, e);
    check("s1_done", d, 1);
    check("s1_error", e, 0);
    check("s1_cur_cfg", cur_cfg, 1);
    check("s1_err_code", err_code, 0);
    @(negedge clk125);
    check("s1_done_one_cycle", done, 0);
    check("s1_busy_after", busy, 0);
    check("s1_reads", rd_count - rd0, NUM_REGS);
    check("s1_writes", wr_count - wr0, NUM_REGS);
    check("s1_queue_drained", exp_q.size(), 0);

    // Out-of-range cfg_sel.
    rd0 = rd_count; wr0 = wr_count;
    pulse_start(2'd3);
    check("s2_error", error, 1);
    check("s2_err_code", err_code, 1);
    check("s2_mmcm_rst", mmcm_rst, 0);
    check("s2_busy", busy, 0);
    @(negedge clk125);
    check("s2_error_one_cycle", error, 0);
    check("s2_no_drp", (rd_count - rd0) + (wr_count - wr0), 0);
    check("s2_cur_cfg", cur_cfg, 1);

    // drdy withheld on the 3rd read.
    rd0 = rd_count;
    withhold_at = rd_count + 3;
    push_cfg(2);
    pulse_start(2'd2);
    wait_end(2000, d, e);
    check("s3_error", e, 1);
    check("s3_err_code", err_code, 2);
    check("s3_mmcm_rst", mmcm_rst, 0);
    check("s3_busy", busy, 0);
    @(negedge clk125);
    check("s3_latency", err_cyc - den_cyc, DRDY_TO + 1);
    check("s3_reads", rd_count - rd0, 3);
    check("s3_cur_cfg", cur_cfg, 1);
    exp_q.delete();
    withhold_at = -1;
    repeat (4) @(negedge clk125);

    // Lock never arrives.
    lock_en = 1'b0;
    push_cfg(2);
    pulse_start(2'd2);
    wait_end(3000, d, e);
    check("s4_error", e, 1);
    check("s4_err_code", err_code, 3);
    check("s4_cur_cfg", cur_cfg, 1);
    check("s4_busy", busy, 0);
    @(negedge clk125);
    check("s4_latency", err_cyc - rel_cyc, LOCK_TO + 1);
    check("s4_queue_drained", exp_q.size(), 0);
    lock_en = 1'b1;
    repeat (4) @(negedge clk125);

    // Second start during the 4th write is ignored.
    wr0 = wr_count;
    push_cfg(0);
    pulse_start(2'd0);
    for (int i = 0; i < 200 && (wr_count - wr0) < 4; i++) @(negedge clk125);
    check("s5_reached_wr4", (wr_count - wr0) >= 4, 1);
    pulse_start(2'd2);
    wait_end(2000, d, e);
    check("s5_done", d, 1);
    check("s5_cur_cfg", cur_cfg, 0);
    @(negedge clk125);
    check("s5_writes", wr_count - wr0, NUM_REGS);
    check("s5_queue_drained", exp_q.size(), 0);

    // Reset during WR_WAIT of register 5, then a clean rerun.
    wr0 = wr_count;
    push_cfg(2);
    pulse_start(2'd2);
    for (int i = 0; i < 200 && (wr_count - wr0) < 5; i++) @(negedge clk125);
    @(negedge clk125);
    check("s6_mmcm_rst_before", mmcm_rst, 1);
    #1 rst = 1'b1;
    #1;
    check("s6_async_mmcm_rst", mmcm_rst, 0);
    check("s6_async_busy", busy, 0);
    check("s6_async_den", den, 0);
    @(negedge clk125);
    rst = 1'b0;
    exp_q.delete();
    check("s6_cur_cfg_reset", cur_cfg, 0);
    repeat (8) @(negedge clk125);
    rd0 = rd_count; wr0 = wr_count;
    push_cfg(1);
    pulse_start(2'd1);
    wait_end(2000, d, e);
    check("s6_done", d, 1);
    check("s6_cur_cfg", cur_cfg, 1);
    @(negedge clk125);
    check("s6_reads", rd_count - rd0, NUM_REGS);
    check("s6_writes", wr_count - wr0, NUM_REGS);
    check("s6_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish before 400000", $time);
    $fatal(1);
  end

endmodule
